branch_resolve_unit: RTL and testbench

Execute-side partner of the tournament branch predictor. It keeps an in-order queue of in-flight predictions issued at fetch. At execute it checks each prediction against the resolved outcome, raises a one-cycle redirect on a mispredict and flushes all younger queue entries. Every resolved branch also drives the predictor's training interface (execute_branch / execute_pc / branch_taken).

---
 rtl/branch_resolve_unit.sv | 133 +++++++++++++
 tb/tb_branch_resolve_unit.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_unit.sv
// Execute-side branch resolution: in-order queue of fetch predictions, checked against
// resolved outcomes to drive fetch redirects, predictor training and performance counters.
module branch_resolve_unit #(
    parameter int DEPTH = 8,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             alloc_valid_i,
    output logic             alloc_ready_o,
    input  logic [31:0]      alloc_pc_i,
    input  logic             alloc_pred_taken_i,
    input  logic [31:0]      alloc_pred_target_i,
    input  logic             resolve_valid_i,
    input  logic [31:0]      resolve_pc_i,
    input  logic             resolve_taken_i,
    input  logic [31:0]      resolve_target_i,
    output logic             redirect_valid_o,
    output logic [31:0]      redirect_pc_o,
    output logic             upd_valid_o,
    output logic [31:0]      upd_pc_o,
    output logic             upd_taken_o,
    output logic [CNT_W-1:0] branch_cnt_o,
    output logic [CNT_W-1:0] mispredict_cnt_o,
    output logic             order_err_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);

    logic [31:0]      pc_mem    [DEPTH];
    logic             taken_mem [DEPTH];
    logic [31:0]      tgt_mem   [DEPTH];

    logic [PTR_W-1:0] head_q, tail_q;
    logic [PTR_W:0]   count_q;

    logic             redir_vld_p1;
    logic [31:0]      redir_pc_p1;
    logic             upd_vld_p1;
    logic [31:0]      upd_pc_p1;
    logic             upd_taken_p1;
    logic [CNT_W-1:0] branch_cnt_q, mispredict_cnt_q;
    logic             order_err_q;

    logic             has_head, push, pop, mispredict, flush, pc_mismatch;
    logic [31:0]      fix_pc;
    logic [PTR_W-1:0] head_nxt;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Ready uses the pre-pop count, so a full queue refuses a push even while popping.
    assign alloc_ready_o = (count_q < DEPTH_C) && !redir_vld_p1;

    always_comb begin
        has_head    = (count_q != '0);
        push        = alloc_valid_i && alloc_ready_o;
        pop         = resolve_valid_i && has_head;
        pc_mismatch = pc_mem[head_q] != resolve_pc_i;
        mispredict  = (taken_mem[head_q] != resolve_taken_i) ||
                      (resolve_taken_i && (tgt_mem[head_q] != resolve_target_i));
        flush       = pop && mispredict;
        fix_pc      = resolve_taken_i ? resolve_target_i : resolve_pc_i + 32'd4;
        head_nxt    = head_q + PTR_W'(1);
    end

    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[tail_q]    <= alloc_pc_i;
            taken_mem[tail_q] <= alloc_pred_taken_i;
            tgt_mem[tail_q]   <= alloc_pred_target_i;
        end
    end

    // Stage p0 -> p1: pop/flush the queue and register redirect, training and counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q           <= '0;
            tail_q           <= '0;
            count_q          <= '0;
            redir_vld_p1     <= 1'b0;
            redir_pc_p1      <= '0;
            upd_vld_p1       <= 1'b0;
            upd_pc_p1        <= '0;
            upd_taken_p1     <= 1'b0;
            branch_cnt_q     <= '0;
            mispredict_cnt_q <= '0;
            order_err_q      <= 1'b0;
        end else begin
            if (pop)
                head_q <= head_nxt;

            if (flush)
                tail_q <= head_nxt;
            else if (push)
                tail_q <= tail_q + PTR_W'(1);

            if (flush)
                count_q <= '0;
            else if (push && !pop)
                count_q <= count_q + (PTR_W+1)'(1);
            else if (pop && !push)
                count_q <= count_q - (PTR_W+1)'(1);

            upd_vld_p1   <= pop;
            redir_vld_p1 <= flush;
            if (pop) begin
                upd_pc_p1    <= resolve_pc_i;
                upd_taken_p1 <= resolve_taken_i;
                branch_cnt_q <= sat_inc(branch_cnt_q);
            end
            if (flush) begin
                redir_pc_p1      <= fix_pc;
                mispredict_cnt_q <= sat_inc(mispredict_cnt_q);
            end

            if (resolve_valid_i && (!has_head || pc_mismatch))
                order_err_q <= 1'b1;
        end
    end

    assign redirect_valid_o = redir_vld_p1;
    assign redirect_pc_o    = redir_pc_p1;
    assign upd_valid_o      = upd_vld_p1;
    assign upd_pc_o         = upd_pc_p1;
    assign upd_taken_o      = upd_taken_p1;
    assign branch_cnt_o     = branch_cnt_q;
    assign mispredict_cnt_o = mispredict_cnt_q;
    assign order_err_o      = order_err_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Bench for branch_resolve_unit: queue-based reference model with an expected-result
// scoreboard, a table of redirect-target vectors and hand-written corner sequences.
module tb_branch_resolve_unit;

    localparam int DEPTH = 8;
    localparam int CNT_W = 32;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             alloc_valid = 1'b0;
    logic             alloc_ready_o;
    logic [31:0]      alloc_pc = '0;
    logic             alloc_pred_taken = 1'b0;
    logic [31:0]      alloc_pred_target = '0;
    logic             resolve_valid = 1'b0;
    logic [31:0]      resolve_pc = '0;
    logic             resolve_taken = 1'b0;
    logic [31:0]      resolve_target = '0;
    logic             redirect_valid_o;
    logic [31:0]      redirect_pc_o;
    logic             upd_valid_o;
    logic [31:0]      upd_pc_o;
    logic             upd_taken_o;
    logic [CNT_W-1:0] branch_cnt_o, mispredict_cnt_o;
    logic             order_err_o;

    branch_resolve_unit #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .alloc_valid_i(alloc_valid), .alloc_ready_o(alloc_ready_o),
        .alloc_pc_i(alloc_pc), .alloc_pred_taken_i(alloc_pred_taken),
        .alloc_pred_target_i(alloc_pred_target),
        .resolve_valid_i(resolve_valid), .resolve_pc_i(resolve_pc),
        .resolve_taken_i(resolve_taken), .resolve_target_i(resolve_target),
        .redirect_valid_o(redirect_valid_o), .redirect_pc_o(redirect_pc_o),
        .upd_valid_o(upd_valid_o), .upd_pc_o(upd_pc_o), .upd_taken_o(upd_taken_o),
        .branch_cnt_o(branch_cnt_o), .mispredict_cnt_o(mispredict_cnt_o),
        .order_err_o(order_err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic        pt;
        logic [31:0] tg;
    } entry_t;

    typedef struct {
        logic [31:0] pc;
        logic        taken;
        logic        mis;
        logic [31:0] rpc;
    } exp_t;

    typedef struct {
        logic [31:0] pc;
        logic        pt;
        logic [31:0] ptg;
        logic        rt;
        logic [31:0] rtg;
        logic        exp_mis;
        logic [31:0] exp_rpc;
    } vec_t;

    entry_t      mq[$];
    exp_t        sb[$];
    logic [31:0] m_bc, m_mc;
    logic        m_oe, m_redir;
    int          n_cmp = 0;
    int          n_bad = 0;

    function automatic logic [31:0] sat32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    task automatic set_push(input logic [31:0] pc, input logic pt, input logic [31:0] tg);
        alloc_valid = 1'b1; alloc_pc = pc; alloc_pred_taken = pt; alloc_pred_target = tg;
    endtask

    task automatic set_resolve(input logic [31:0] pc, input logic t, input logic [31:0] tg);
        resolve_valid = 1'b1; resolve_pc = pc; resolve_taken = t; resolve_target = tg;
    endtask

    // One clock: advance the model with the driven inputs, clock the DUT, check outputs.
    task automatic cycle();
        logic   exp_ready, do_push, expect_out, mis;
        entry_t h;
        exp_t   e;
        expect_out = 1'b0;
        exp_ready  = (mq.size() < DEPTH) && !m_redir;
        chk("alloc_ready", {63'd0, alloc_ready_o}, {63'd0, exp_ready});
        do_push = alloc_valid && exp_ready;
        m_redir = 1'b0;
        if (resolve_valid) begin
            if (mq.size() > 0) begin
                h = mq.pop_front();
                if (h.pc != resolve_pc) m_oe = 1'b1;
                mis = (h.pt != resolve_taken) || (resolve_taken && (h.tg != resolve_target));
                e.pc = resolve_pc; e.taken = resolve_taken; e.mis = mis;
                e.rpc = resolve_taken ? resolve_target : resolve_pc + 32'd4;
                sb.push_back(e);
                expect_out = 1'b1;
                m_bc = sat32(m_bc);
                if (mis) begin
                    m_mc = sat32(m_mc);
                    mq.delete();
                    m_redir = 1'b1;
                    do_push = 1'b0;
                end
            end else begin
                m_oe = 1'b1;
            end
        end
        if (do_push) mq.push_back('{alloc_pc, alloc_pred_taken, alloc_pred_target});
        @(posedge clk);
        #1;
        alloc_valid   = 1'b0;
        resolve_valid = 1'b0;
        chk("upd_valid", {63'd0, upd_valid_o}, {63'd0, expect_out});
        if (upd_valid_o) begin
            if (sb.size() == 0) begin
                chk("upd_spurious", {63'd0, upd_valid_o}, 64'd0);
            end else begin
                e = sb.pop_front();
                chk("upd_pc", {32'd0, upd_pc_o}, {32'd0, e.pc});
                chk("upd_taken", {63'd0, upd_taken_o}, {63'd0, e.taken});
                chk("redirect_valid", {63'd0, redirect_valid_o}, {63'd0, e.mis});
                if (e.mis) chk("redirect_pc", {32'd0, redirect_pc_o}, {32'd0, e.rpc});
            end
        end else begin
            chk("redirect_idle", {63'd0, redirect_valid_o}, 64'd0);
        end
        sb.delete();
        chk("branch_cnt", {32'd0, branch_cnt_o}, {32'd0, m_bc});
        chk("mispredict_cnt", {32'd0, mispredict_cnt_o}, {32'd0, m_mc});
        chk("order_err", {63'd0, order_err_o}, {63'd0, m_oe});
        chk("count", 64'(dut.count_q), 64'(mq.size()));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        alloc_valid = 1'b0;
        resolve_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        mq.delete(); sb.delete();
        m_bc = '0; m_mc = '0; m_oe = 1'b0; m_redir = 1'b0;
        chk("rst_ready", {63'd0, alloc_ready_o}, 64'd1);
        chk("rst_redirect_valid", {63'd0, redirect_valid_o}, 64'd0);
        chk("rst_redirect_pc", {32'd0, redirect_pc_o}, 64'd0);
        chk("rst_upd_valid", {63'd0, upd_valid_o}, 64'd0);
        chk("rst_upd_pc", {32'd0, upd_pc_o}, 64'd0);
        chk("rst_upd_taken", {63'd0, upd_taken_o}, 64'd0);
        chk("rst_branch_cnt", {32'd0, branch_cnt_o}, 64'd0);
        chk("rst_mispredict_cnt", {32'd0, mispredict_cnt_o}, 64'd0);
        chk("rst_order_err", {63'd0, order_err_o}, 64'd0);
        chk("rst_count", 64'(dut.count_q), 64'd0);
    endtask

    vec_t vecs[6];

    initial begin
        vecs[0] = '{32'h0000_01FC, 1'b1, 32'h0000_0500, 1'b0, 32'h0, 1'b1, 32'h0000_0200};
        vecs[1] = '{32'hFFFF_FFFC, 1'b1, 32'h0000_0010, 1'b0, 32'h0, 1'b1, 32'h0000_0000};
        vecs[2] = '{32'h0000_0100, 1'b1, 32'h0000_0400, 1'b1, 32'h0000_0480, 1'b1, 32'h0000_0480};
        vecs[3] = '{32'h0000_0100, 1'b1, 32'h0000_0400, 1'b1, 32'h0000_0400, 1'b0, 32'h0};
        vecs[4] = '{32'h0000_0200, 1'b0, 32'h0,         1'b1, 32'h0000_0600, 1'b1, 32'h0000_0600};
        vecs[5] = '{32'h0000_0300, 1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 32'h0};

        do_reset();

        // Three correct not-taken branches, resolved back to back.
        set_push(32'h100, 1'b0, 32'h0); cycle();
        set_push(32'h200, 1'b0, 32'h0); cycle();
        set_push(32'h300, 1'b0, 32'h0); cycle();
        set_resolve(32'h100, 1'b0, 32'h0); cycle();
        set_resolve(32'h200, 1'b0, 32'h0); cycle();
        set_resolve(32'h300, 1'b0, 32'h0); cycle();
        chk("seq1_branch_cnt", {32'd0, branch_cnt_o}, 64'd3);
        chk("seq1_mispredict_cnt", {32'd0, mispredict_cnt_o}, 64'd0);

        // Taken-target mispredict flushes a younger entry.
        do_reset();
        set_push(32'h100, 1'b1, 32'h400); cycle();
        set_push(32'h104, 1'b0, 32'h0); cycle();
        set_resolve(32'h100, 1'b1, 32'h480); cycle();
        chk("seq2_redirect_pc", {32'd0, redirect_pc_o}, 64'h480);
        chk("seq2_count", 64'(dut.count_q), 64'd0);
        chk("seq2_ready_n1", {63'd0, alloc_ready_o}, 64'd0);
        cycle();
        chk("seq2_ready_n2", {63'd0, alloc_ready_o}, 64'd1);
        chk("seq2_mispredict_cnt", {32'd0, mispredict_cnt_o}, 64'd1);

        // Redirect-target table.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            set_push(vecs[i].pc, vecs[i].pt, vecs[i].ptg); cycle();
            set_resolve(vecs[i].pc, vecs[i].rt, vecs[i].rtg); cycle();
            chk($sformatf("vec%0d_redirect_valid", i), {63'd0, redirect_valid_o},
                {63'd0, vecs[i].exp_mis});
            if (vecs[i].exp_mis)
                chk($sformatf("vec%0d_redirect_pc", i), {32'd0, redirect_pc_o},
                    {32'd0, vecs[i].exp_rpc});
            cycle();
        end

        // Full queue refuses a push even alongside a pop; then wrap pointers.
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            set_push(32'h1000 + 32'(4 * i), 1'b0, 32'h0); cycle();
        end
        chk("full_ready", {63'd0, alloc_ready_o}, 64'd0);
        set_push(32'h2000, 1'b0, 32'h0);
        set_resolve(32'h1000, 1'b0, 32'h0);
        cycle();
        chk("full_count", 64'(dut.count_q), 64'd7);
        for (int i = 0; i < 20; i++) begin
            set_push(32'h3000 + 32'(4 * i), 1'b0, 32'h0);
            set_resolve((i < 7) ? 32'h1004 + 32'(4 * i) : 32'h3000 + 32'(4 * (i - 7)), 1'b0, 32'h0);
            cycle();
        end
        chk("wrap_order_err", {63'd0, order_err_o}, 64'd0);
        chk("wrap_branch_cnt", {32'd0, branch_cnt_o}, 64'd21);

        // Resolve on an empty queue.
        do_reset();
        set_resolve(32'h500, 1'b0, 32'h0); cycle();
        chk("empty_order_err", {63'd0, order_err_o}, 64'd1);
        chk("empty_upd_valid", {63'd0, upd_valid_o}, 64'd0);
        chk("empty_branch_cnt", {32'd0, branch_cnt_o}, 64'd0);

        // PC mismatch with head still pops.
        do_reset();
        set_push(32'h100, 1'b0, 32'h0); cycle();
        set_push(32'h200, 1'b0, 32'h0); cycle();
        set_resolve(32'h300, 1'b0, 32'h0); cycle();
        chk("mism_order_err", {63'd0, order_err_o}, 64'd1);
        chk("mism_count", 64'(dut.count_q), 64'd1);
        chk("mism_upd_pc", {32'd0, upd_pc_o}, 64'h300);
        set_resolve(32'h200, 1'b0, 32'h0); cycle();

        // Mispredict with a simultaneous wrong-path push, then reset with entries queued.
        do_reset();
        set_push(32'h100, 1'b0, 32'h0); cycle();
        set_push(32'h104, 1'b0, 32'h0); cycle();
        set_push(32'h108, 1'b0, 32'h0); cycle();
        set_resolve(32'h100, 1'b1, 32'h900);
        set_push(32'h10C, 1'b0, 32'h0);
        cycle();
        chk("flush_count", 64'(dut.count_q), 64'd0);
        chk("flush_redirect_pc", {32'd0, redirect_pc_o}, 64'h900);
        cycle();
        for (int i = 0; i < 5; i++) begin
            set_push(32'h900 + 32'(4 * i), 1'b0, 32'h0); cycle();
        end
        chk("pre_rst_count", 64'(dut.count_q), 64'd5);
        set_resolve(32'h900, 1'b1, 32'h700);
        do_reset();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
